// File: rtl/axi_line_arbiter.sv
// axi_line_arbiter: whole-line fill/writeback engine onto one AXI4 master.
// Define MEM_ARB_RR_EN for round-robin grants; default is fixed priority.
module axi_line_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ID_WIDTH    = 13,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int LINE_BYTES  = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  input  logic [NUM_CLIENTS-1:0]            req_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*LINE_BYTES*8-1:0] req_wline,
  output logic [NUM_CLIENTS-1:0]            resp_valid,
  output logic [LINE_BYTES*8-1:0]           resp_rline,
  output logic                              resp_err,
  output logic [ID_WIDTH-1:0]               m_axi_arid,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic [1:0]                        m_axi_arburst,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  output logic [ID_WIDTH-1:0]               m_axi_awid,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [ID_WIDTH-1:0]               m_axi_bid,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int LW    = LINE_BYTES * 8;
  localparam int BEATS = LW / DATA_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int CW    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           grant;
  logic                    wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LW-1:0]           wline;
  logic [LW-1:0]           rline;
  logic [BW-1:0]           beat;
  logic                    err;
  logic [CW-1:0]           ptr;
  logic [CW-1:0]           pick;
  logic                    any_req;
  logic [2*NUM_CLIENTS-1:0] dbl;
  logic [NUM_CLIENTS-1:0]  rot;
  int                      off;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LW-1:0]           sel_line;
  logic                    sel_wr;
  logic                    last_beat;

  assign last_beat  = (beat == BW'(BEATS - 1));
  assign resp_rline = rline;

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: next search starts one past the last grant.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (state == S_IDLE && any_req)
      ptr <= CW'((int'(pick) + 1) % NUM_CLIENTS);
  end
`else
  assign ptr = '0;
`endif

  // Rotate requests so the search starts at ptr; lowest offset wins.
  always_comb begin
    dbl     = {req_valid, req_valid} >> ptr;
    rot     = dbl[NUM_CLIENTS-1:0];
    off     = 0;
    any_req = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = i;
        any_req = 1'b1;
      end
    end
    pick = CW'((int'(ptr) + off) % NUM_CLIENTS);
  end

  // Mux the chosen client's request payload.
  always_comb begin
    sel_addr = '0;
    sel_line = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick == CW'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_line = req_wline[i*LW +: LW];
        sel_wr   = req_write[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Operation context, beat counter, fill assembly and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= '0;
      wr    <= 1'b0;
      addr  <= '0;
      wline <= '0;
      rline <= '0;
      beat  <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (any_req) begin
          grant <= pick;
          wr    <= sel_wr;
          addr  <= {sel_addr[ADDR_WIDTH-1:OFF], OFF'(0)};
          wline <= sel_line;
          beat  <= '0;
          err   <= 1'b0;
        end
        S_R: if (m_axi_rvalid) begin
          for (int k = 0; k < BEATS; k++)
            if (beat == BW'(k))
              rline[k*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
          beat <= beat + 1'b1;
          if (m_axi_rresp[1] || (m_axi_rlast && !last_beat))
            err <= 1'b1;
        end
        S_W: if (m_axi_wready) beat <= beat + 1'b1;
        S_B: if (m_axi_bvalid && m_axi_bresp[1]) err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and bus/response outputs, all decoded from state.
  always_comb begin
    state_nxt     = state;
    m_axi_arid    = ID_WIDTH'(grant);
    m_axi_araddr  = addr;
    m_axi_arlen   = 8'(BEATS - 1);
    m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    m_axi_arburst = 2'b01;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awid    = ID_WIDTH'(grant);
    m_axi_awaddr  = addr;
    m_axi_awlen   = 8'(BEATS - 1);
    m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
    m_axi_awburst = 2'b01;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '1;
    m_axi_wlast   = last_beat;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    resp_valid    = '0;
    resp_err      = 1'b0;
    for (int k = 0; k < BEATS; k++)
      if (beat == BW'(k))
        m_axi_wdata = wline[k*DATA_WIDTH +: DATA_WIDTH];
    unique case (state)
      S_IDLE: if (any_req) state_nxt = sel_wr ? S_AW : S_AR;
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) state_nxt = S_RESP;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat) state_nxt = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < NUM_CLIENTS; i++)
          resp_valid[i] = (grant == CW'(i));
        resp_err  = err;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{m_axi_bid, m_axi_rresp[0], m_axi_bresp[0],
                         sel_addr[OFF-1:0], wr};

endmodule

// File: tb/tb_axi_line_arbiter.sv
// tb_axi_line_arbiter: directed checks of fills, writebacks, arbitration,
// error reporting, mid-burst reset and address-channel stall.
`timescale 1ns/1ps
module tb_axi_line_arbiter;
  localparam int N = 2, IDW = 13, AW = 64, DW = 64, LB = 64;
  localparam int LW = LB * 8;

  logic            clk, reset;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_wline;
  logic [N-1:0]    resp_valid;
  logic [LW-1:0]   resp_rline;
  logic            resp_err;
  logic [IDW-1:0]  m_axi_arid, m_axi_awid, m_axi_bid;
  logic [AW-1:0]   m_axi_araddr, m_axi_awaddr;
  logic [7:0]      m_axi_arlen, m_axi_awlen;
  logic [2:0]      m_axi_arsize, m_axi_awsize;
  logic [1:0]      m_axi_arburst, m_axi_awburst;
  logic            m_axi_arvalid, m_axi_arready;
  logic [DW-1:0]   m_axi_rdata, m_axi_wdata;
  logic [1:0]      m_axi_rresp, m_axi_bresp;
  logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic            m_axi_bvalid, m_axi_bready;

  axi_line_arbiter #(
    .NUM_CLIENTS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .LINE_BYTES(LB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wline(req_wline),
    .resp_valid(resp_valid), .resp_rline(resp_rline),
    .resp_err(resp_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave knobs and logs.
  bit            ar_ok = 1'b1;
  bit            w_tog = 1'b0;
  int            err_beat = -1;
  int            lst_beat = 7;
  logic [63:0]   rbase = 64'hA0;
  bit            r_act, b_pend, aw_done, w_early;
  int            r_k;
  bit            hs_ar, hs_r, hs_aw, hs_w, hs_b, hs_rl, hs_wl;
  int            n_ar = 0, n_r = 0, n_w = 0;
  logic [AW-1:0] ar_addr_l, aw_addr_l;
  logic [7:0]    ar_len_l, aw_len_l;
  logic [2:0]    ar_size_l;
  logic [1:0]    ar_burst_l;
  logic [IDW-1:0] ar_id_l, aw_id_l;
  logic [DW-1:0] w_data_l [16];
  logic [15:0]   w_last_l = '0;
  bit            w_strb_bad = 1'b0;

  // AXI slave: consume last cycle's handshakes, drive, then log new ones.
  always @(negedge clk) begin
    if (reset) begin
      {r_act, b_pend, aw_done, w_early} = '0;
      {hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
      r_k = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
      m_axi_rresp = 0; m_axi_rlast = 0; m_axi_awready = 0;
      m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_bid = '0;
    end else begin
      if (hs_ar) begin r_act = 1; r_k = 0; end
      if (hs_r) begin
        if (hs_rl) r_act = 0;
        r_k++;
      end
      if (hs_aw) aw_done = 1;
      if (hs_w && hs_wl) b_pend = 1;
      if (hs_b) begin b_pend = 0; aw_done = 0; end
      m_axi_arready = ar_ok;
      m_axi_rvalid  = r_act;
      m_axi_rdata   = rbase + 64'(r_k);
      m_axi_rresp   = (r_k == err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast   = (r_k == lst_beat);
      m_axi_awready = 1'b1;
      m_axi_wready  = w_tog ? ~m_axi_wready : 1'b1;
      m_axi_bvalid  = b_pend;
      m_axi_bresp   = 2'b00;
      m_axi_bid     = aw_id_l;
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      hs_rl = m_axi_rlast;
      hs_aw = m_axi_awvalid && m_axi_awready;
      hs_w  = m_axi_wvalid && m_axi_wready;
      hs_wl = m_axi_wlast;
      hs_b  = m_axi_bvalid && m_axi_bready;
      if (hs_ar) begin
        n_ar++;
        ar_addr_l = m_axi_araddr; ar_len_l = m_axi_arlen;
        ar_size_l = m_axi_arsize; ar_burst_l = m_axi_arburst;
        ar_id_l = m_axi_arid;
      end
      if (hs_r) n_r++;
      if (hs_aw) begin
        aw_addr_l = m_axi_awaddr; aw_len_l = m_axi_awlen;
        aw_id_l = m_axi_awid;
      end
      if (hs_w) begin
        if (!aw_done && !hs_aw) w_early = 1;
        if (n_w < 16) begin
          w_data_l[n_w] = m_axi_wdata;
          w_last_l[n_w] = m_axi_wlast;
        end
        if (m_axi_wstrb != '1) w_strb_bad = 1;
        n_w++;
      end
    end
  end

  // Grant log and request-hold rule.
  int      glog [$];
  logic [N-1:0] pend = '0;
  always @(negedge clk) begin
    #2;
    if (reset) pend = '0;
    else begin
      for (int i = 0; i < N; i++)
        if (resp_valid[i]) begin
          pend[i] = 1'b0;
          glog.push_back(i);
        end
      for (int i = 0; i < N; i++)
        if (pend[i]) check("req_hold", req_valid[i], 1'b1);
      pend = pend | req_valid;
    end
  end

  function automatic logic [LW-1:0] exp_line(input logic [63:0] b);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = b + 64'(k);
    return l;
  endfunction

  // Issue one op for client c, return at the negedge showing its resp.
  task automatic run_op(input int c, input bit w, input logic [63:0] a,
                        input logic [LW-1:0] line, output int cyc);
    req_write[c] = w;
    req_addr[c*AW +: AW] = a;
    req_wline[c*LW +: LW] = line;
    req_valid[c] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid[c] && cyc < 300);
    if (!resp_valid[c]) check("resp_timeout", 0, 1);
  endtask

  task automatic drop(input int c);
    req_valid[c] = 1'b0;
    @(negedge clk);
  endtask

  int cyc, base, nr0, bad, rv;
  int cnt [N];
  logic [LW-1:0] wl;
  int exp_g [6];

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wline = '0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_rline", resp_rline, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: fill, zero-wait slave.
    run_op(0, 0, 64'h1234, '0, cyc);
    check("t1_latency", cyc + 1, 11);
    check("t1_resp_valid", resp_valid, 2'b01);
    check("t1_rline", resp_rline, exp_line(64'hA0));
    check("t1_err", resp_err, 0);
    check("t1_araddr", ar_addr_l, 64'h1200);
    check("t1_arlen", ar_len_l, 7);
    check("t1_arsize", ar_size_l, 3);
    check("t1_arburst", ar_burst_l, 1);
    check("t1_arid", ar_id_l, 0);
    drop(0);

    // 2: writeback with toggling wready.
    w_tog = 1'b1;
    for (int k = 0; k < 8; k++)
      wl[k*64 +: 64] = {32'hB00D_0000 + 32'(k), 32'hC0DE_0000 + 32'(k)};
    run_op(1, 1, 64'h80, wl, cyc);
    check("t2_resp_valid", resp_valid, 2'b10);
    check("t2_err", resp_err, 0);
    check("t2_awaddr", aw_addr_l, 64'h80);
    check("t2_awid", aw_id_l, 1);
    check("t2_awlen", aw_len_l, 7);
    check("t2_nbeats", n_w, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t2_wdata%0d", k), w_data_l[k], wl[k*64 +: 64]);
    check("t2_wlast", w_last_l, 16'h0080);
    check("t2_wstrb", w_strb_bad, 0);
    check("t2_aw_first", w_early, 0);
    drop(1);
    w_tog = 1'b0;

    // 3: simultaneous requests, three ops each.
    base = glog.size();
    cnt[0] = 0; cnt[1] = 0;
    req_write = '0; req_addr = '0;
    req_valid = 2'b11;
    cyc = 0;
    while ((cnt[0] < 3 || cnt[1] < 3) && cyc < 800) begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < N; c++)
        if (resp_valid[c]) begin
          cnt[c]++;
          if (cnt[c] == 3) req_valid[c] = 1'b0;
        end
    end
    #3;
`ifdef MEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 1, 1, 1};
`endif
    check("t3_count", glog.size() - base, 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_grant%0d", k), glog[base + k], exp_g[k]);
    @(negedge clk);

    // 4: SLVERR on beat 3, then a clean op.
    err_beat = 3;
    run_op(0, 0, 64'h2000, '0, cyc);
    check("t4_err_valid", resp_valid, 2'b01);
    check("t4_err", resp_err, 1);
    drop(0);
    err_beat = -1;
    run_op(1, 0, 64'h2040, '0, cyc);
    check("t4_clean_err", resp_err, 0);
    check("t4_clean_line", resp_rline, exp_line(64'hA0));
    drop(1);

    // Early rlast on beat 4 still completes, flagged as error.
    lst_beat = 4;
    run_op(0, 0, 64'h3000, '0, cyc);
    check("t4b_valid", resp_valid, 2'b01);
    check("t4b_err", resp_err, 1);
    drop(0);
    lst_beat = 7;

    // 5: reset during R beat 4.
    req_addr[0 +: AW] = 64'h100;
    req_write[0] = 1'b0;
    req_valid[0] = 1'b1;
    bad = 1;
    for (int i = 0; i < 60 && bad == 1; i++) begin
      @(negedge clk);
      #1;
      if (m_axi_rvalid && m_axi_rready && m_axi_rdata == 64'hA4)
        bad = 0;
    end
    check("t5_reached_beat4", bad, 0);
    reset = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    check("t5_arvalid", m_axi_arvalid, 0);
    check("t5_rready", m_axi_rready, 0);
    check("t5_awvalid", m_axi_awvalid, 0);
    check("t5_wvalid", m_axi_wvalid, 0);
    check("t5_bready", m_axi_bready, 0);
    check("t5_resp_valid", resp_valid, 0);
    check("t5_resp_err", resp_err, 0);
    check("t5_rline", resp_rline, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rbase = 64'h5550;
    run_op(0, 0, 64'h140, '0, cyc);
    check("t5_fresh_lat", cyc + 1, 11);
    check("t5_fresh_line", resp_rline, exp_line(64'h5550));
    check("t5_fresh_err", resp_err, 0);
    check("t5_fresh_addr", ar_addr_l, 64'h140);
    drop(0);
    rbase = 64'hA0;

    // 6: arready held low for 20 cycles.
    ar_ok = 1'b0;
    @(negedge clk);
    nr0 = n_r;
    bad = 0; rv = 0;
    req_addr[1*AW +: AW] = 64'h3C5;
    req_write[1] = 1'b0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_axi_arvalid || m_axi_araddr != 64'h3C0 ||
          m_axi_arlen != 8'd7 || m_axi_arid != 13'd1) bad++;
      if (resp_valid != '0) rv++;
    end
    check("t6_ar_stable", bad, 0);
    check("t6_no_resp", rv, 0);
    check("t6_no_r", n_r - nr0, 0);
    ar_ok = 1'b1;
    run_op(1, 0, 64'h3C5, '0, cyc);
    check("t6_resp_valid", resp_valid, 2'b10);
    check("t6_line", resp_rline, exp_line(64'hA0));
    drop(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
